register_bank: RTL and testbench
================================

# register_bank

General-purpose register file for the 16-bit processor: the receiving end of the write-back stage. It accepts the write-back result (ALU result or memory read data, already selected) and supplies two operands to decode. It write-through bypasses a same-cycle write to the read ports. A load scoreboard tracks destinations of in-flight loads and raises `stall` when decode reads a register whose load data has not yet been written back.

## Interface
- `DATA_WIDTH`, 16, register and data width.
- `ADDR_WIDTH`, 4, register address width; register count is 2^ADDR_WIDTH.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `RegWrite`  in  1  write-back enable.
- `MemtoReg`  in  1  write-back value comes from memory (load completion).
- `writeReg`  in  ADDR_WIDTH  write-back destination.
- `writeData`  in  DATA_WIDTH  write-back value (write-back mux output).
- `readReg1`, `readReg2`  in  ADDR_WIDTH  decode source addresses.
- `readData1`, `readData2`  out  DATA_WIDTH  source operands (combinational).
- `issueValid`  in  1  decode issues an instruction this cycle.
- `issueLoad`  in  1  issued instruction is a load.
- `issueDest`  in  ADDR_WIDTH  destination of the issued instruction.
- `stall`  out  1  decode must hold: a source register has a pending load.

## Operation
- Storage is 2^ADDR_WIDTH × DATA_WIDTH. Register 0 always reads 0. Writes to register 0 are discarded and never set pending.
- **Write:** on the rising edge, if `RegWrite` is high and `writeReg` ≠ 0, then `regs[writeReg]` ← `writeData`.
- **Read:** `readDataN` is computed combinationally as follows.
  - 0 if `readRegN` = 0.
  - Otherwise `writeData` if `RegWrite` is high and `writeReg` = `readRegN` (write-first bypass).
  - Otherwise `regs[readRegN]`.
- **Scoreboard:** one pending bit per register.
  - Set: rising edge with `issueValid` & `issueLoad` & `issueDest` ≠ 0 and `stall` low sets `pending[issueDest]`.
  - Clear: rising edge with `RegWrite` & `MemtoReg` clears `pending[writeReg]`.
  - Set and clear of the same register on the same edge: set wins, because the new load is younger.
  - A non-load write-back (`MemtoReg` = 0) never clears a pending bit.
  - An issue while `stall` is high is ignored by the scoreboard.
- **stall:** combinational, equal to `hit(readReg1)` | `hit(readReg2)`.
  - `hit(r)` = `pending[r]` & (r ≠ 0) & ~(`RegWrite` & `MemtoReg` & `writeReg` = r).
  - A load completing this cycle does not stall, because the bypass delivers its data.
- **Reset:** all registers are cleared to 0 and all pending bits are cleared. Any in-flight scoreboard state is lost; reset mid-operation leaves no register pending.
- `issueValid` gates both stall generation and scoreboard update. Decode must hold `readRegN` stable while stalled.

## Timing
- Write latency is 1 edge. The written value is visible on the read ports in the same cycle via the bypass, and from `regs` from the next cycle on.
- Read latency is 0 (combinational). No read-side registers.
- Pending is set 1 edge after issue. `stall` for a dependent read asserts in the cycle after the load issues.
- `stall` deasserts combinationally in the cycle the load's write-back is presented.
- During reset-asserted cycles, writes and scoreboard sets are ignored. All register outputs read 0, except the bypass path, which still forwards `writeData` when `RegWrite` is high.
- After reset releases: `readData1` = `readData2` = 0 for all addresses, and `stall` = 0.

## Test plan
- **Reset:** assert `reset` 1 cycle, then read registers 1..15 → all 0, `stall` = 0.
- **Write/read:** write 0xBEEF to r5, then read r5 and r0 on the next cycle → `readData1` = 0xBEEF, `readData2` = 0. Write 0x1234 to r0 → r0 still reads 0.
- **Bypass:** `RegWrite` = 1, `writeReg` = 7, `writeData` = 0xA5A5, `readReg2` = 7 in the same cycle → `readData2` = 0xA5A5 before the edge.
- **Load stall:** issue a load to r3, then read r3 next cycle → `stall` = 1. Stall persists across ALU write-backs to r3 with `MemtoReg` = 0. Present `RegWrite` = `MemtoReg` = 1, r3, 0x00FF → `stall` = 0 and `readData1` = 0x00FF in that cycle.
- **Simultaneous set/clear:** a load write-back to r4 on the same edge as a new load issue to r4 → r4 remains pending and the next read of r4 stalls.
- **Reset mid-operation:** r2 and r9 pending, assert `reset` → after release, reading r2 and r9 gives `stall` = 0 and data 0.

Source files
------------

// File: rtl/register_bank_if.sv
// rtl/register_bank_if.sv - write-back, operand-read and issue signals of the register bank
//
// Purpose: groups every bus signal between the pipeline and register_bank.
// Ports (by modport):
//   master - pipeline side: drives
//            RegWrite/MemtoReg/writeReg/writeData,
//            readReg1/readReg2 and issueValid/issueLoad/issueDest;
//            receives readData1/readData2 and stall.
//   slave  - register bank side, with the opposite directions.
interface register_bank_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [ADDR_WIDTH-1:0] writeReg;
    logic [DATA_WIDTH-1:0] writeData;
    logic [ADDR_WIDTH-1:0] readReg1;
    logic [ADDR_WIDTH-1:0] readReg2;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic                  issueValid;
    logic                  issueLoad;
    logic [ADDR_WIDTH-1:0] issueDest;
    logic                  stall;

    modport master (
        output RegWrite, MemtoReg, writeReg, writeData,
        output readReg1, readReg2,
        output issueValid, issueLoad, issueDest,
        input  readData1, readData2, stall
    );

    modport slave (
        input  RegWrite, MemtoReg, writeReg, writeData,
        input  readReg1, readReg2,
        input  issueValid, issueLoad, issueDest,
        output readData1, readData2, stall
    );
endinterface

// File: rtl/register_bank.sv
// rtl/register_bank.sv - general-purpose register file with write-first bypass and load scoreboard
//
// Purpose: 2^ADDR_WIDTH x DATA_WIDTH register file. Register 0 is hardwired to zero.
// It has two combinational read ports. A same-cycle write-back is forwarded to
// the read ports. A pending-load scoreboard drives stall.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous, active-high
//   bus   - register_bank_if.slave: write-back, operand reads, issue, stall
module register_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    register_bank_if.slave  bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0]      pending;

    logic loadDone;
    logic hit1;
    logic hit2;
    logic stallInt;
    logic setPending;

    assign loadDone = bus.RegWrite && bus.MemtoReg;

    // Reset masks stored state immediately, but the bypass still forwards
    // writeData so a write-back presented during reset is visible.
    function automatic logic [DATA_WIDTH-1:0] readPort(
        input logic [ADDR_WIDTH-1:0] r,
        input logic                  wen,
        input logic [ADDR_WIDTH-1:0] wreg,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic                  rst,
        input logic [DATA_WIDTH-1:0] stored
    );
        logic [DATA_WIDTH-1:0] v;
        if (r == '0)
            v = '0;
        else if (wen && (wreg == r))
            v = wdata;
        else if (rst)
            v = '0;
        else
            v = stored;
        return v;
    endfunction

    // A load whose data is being written back this cycle does not stall:
    // the bypass already delivers its data.
    function automatic logic pendingHit(
        input logic [ADDR_WIDTH-1:0] r,
        input logic                  isPending,
        input logic                  done,
        input logic [ADDR_WIDTH-1:0] wreg
    );
        return isPending && (r != '0) && !(done && (wreg == r));
    endfunction

    always_comb begin
        bus.readData1 = readPort(bus.readReg1, bus.RegWrite, bus.writeReg,
                                 bus.writeData, reset, regs[bus.readReg1]);
        bus.readData2 = readPort(bus.readReg2, bus.RegWrite, bus.writeReg,
                                 bus.writeData, reset, regs[bus.readReg2]);
    end

    always_comb begin
        hit1     = pendingHit(bus.readReg1, pending[bus.readReg1], loadDone, bus.writeReg);
        hit2     = pendingHit(bus.readReg2, pending[bus.readReg2], loadDone, bus.writeReg);
        stallInt = !reset && bus.issueValid && (hit1 || hit2);
    end

    assign bus.stall = stallInt;

    // A stalled issue does not occupy the scoreboard.
    assign setPending = bus.issueValid && bus.issueLoad && (bus.issueDest != '0) && !stallInt;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (bus.RegWrite && (bus.writeReg != '0)) begin
                regs[bus.writeReg] <= bus.writeData;
            end
            // The set is ordered after the clear, so the younger load wins
            // when both target the same register on the same edge.
            if (loadDone) begin
                pending[bus.writeReg] <= 1'b0;
            end
            if (setPending) begin
                pending[bus.issueDest] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - randomized and directed self-checking bench for register_bank
module tb_register_bank;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    register_bank_if bus ();

    register_bank dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checkCount = 0;
    int passCount  = 0;

    logic [15:0] modelRegs [16];
    bit          modelPending [16];

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] expected);
        checkCount++;
        if (got === expected)
            passCount++;
        else
            $display("FAIL %s: got %0h, expected %0h", tag, got, expected);
    endtask

    function automatic logic [15:0] modelRead(input int r);
        if (r == 0) return 16'h0;
        if (bus.RegWrite && (int'(bus.writeReg) == r)) return bus.writeData;
        if (reset) return 16'h0;
        return modelRegs[r];
    endfunction

    function automatic bit modelBlocked(input int r);
        bit completing;
        completing = bus.RegWrite && bus.MemtoReg && (int'(bus.writeReg) == r);
        return (r != 0) && modelPending[r] && !completing;
    endfunction

    task automatic drive(input bit rst, input bit rw, input bit m2r, input int wr,
                         input logic [15:0] wd, input int r1, input int r2,
                         input bit iv, input bit il, input int id);
        reset          = rst;
        bus.RegWrite   = rw;
        bus.MemtoReg   = m2r;
        bus.writeReg   = wr[3:0];
        bus.writeData  = wd;
        bus.readReg1   = r1[3:0];
        bus.readReg2   = r2[3:0];
        bus.issueValid = iv;
        bus.issueLoad  = il;
        bus.issueDest  = id[3:0];
    endtask

    // Check the outputs for the inputs currently applied. Then take one edge
    // and advance the reference model with the same inputs.
    task automatic cycle(input string tag, input bit chk, input logic [15:0] x1,
                         input logic [15:0] x2, input bit xs);
        logic [15:0] e1;
        logic [15:0] e2;
        bit          es;
        int          wr;
        int          id;
        #1;
        e1 = modelRead(int'(bus.readReg1));
        e2 = modelRead(int'(bus.readReg2));
        es = !reset && bus.issueValid &&
             (modelBlocked(int'(bus.readReg1)) || modelBlocked(int'(bus.readReg2)));
        checkValue({tag, ".rd1"}, 32'(bus.readData1), 32'(e1));
        checkValue({tag, ".rd2"}, 32'(bus.readData2), 32'(e2));
        if (!reset) checkValue({tag, ".stall"}, 32'(bus.stall), 32'(es));
        if (chk) begin
            checkValue({tag, ".rd1c"}, 32'(bus.readData1), 32'(x1));
            checkValue({tag, ".rd2c"}, 32'(bus.readData2), 32'(x2));
            checkValue({tag, ".stallc"}, 32'(bus.stall), 32'(xs));
        end
        @(posedge clock);
        wr = int'(bus.writeReg);
        id = int'(bus.issueDest);
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                modelRegs[i]    = 16'h0;
                modelPending[i] = 1'b0;
            end
        end else begin
            if (bus.RegWrite && wr != 0) modelRegs[wr] = bus.writeData;
            if (bus.RegWrite && bus.MemtoReg) modelPending[wr] = 1'b0;
            if (bus.issueValid && bus.issueLoad && id != 0 && !es) modelPending[id] = 1'b1;
        end
        #2;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            modelRegs[i]    = 16'h0;
            modelPending[i] = 1'b0;
        end

        // reset, then every register reads zero
        drive(1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        cycle("reset", 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            drive(0, 0, 0, 0, 16'h0, i, 16 - i, 1, 0, 0);
            cycle("post_reset", 1'b1, 16'h0, 16'h0, 1'b0);
        end

        // write/read, r0 immune to writes
        drive(0, 1, 0, 5, 16'hBEEF, 0, 0, 0, 0, 0);
        cycle("wr_r5", 1'b0, 16'h0, 16'h0, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 5, 0, 1, 0, 0);
        cycle("rd_r5", 1'b1, 16'hBEEF, 16'h0, 1'b0);
        drive(0, 1, 0, 0, 16'h1234, 0, 0, 0, 0, 0);
        cycle("wr_r0", 1'b0, 16'h0, 16'h0, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 0, 0, 1, 0, 0);
        cycle("rd_r0", 1'b1, 16'h0, 16'h0, 1'b0);

        // write-first bypass
        drive(0, 1, 0, 7, 16'hA5A5, 0, 7, 1, 0, 0);
        cycle("bypass", 1'b1, 16'h0, 16'hA5A5, 1'b0);

        // load stall, ALU write-back does not clear, load write-back does
        drive(0, 0, 0, 0, 16'h0, 0, 0, 1, 1, 3);
        cycle("issue_r3", 1'b1, 16'h0, 16'h0, 1'b0);
        drive(0, 1, 0, 3, 16'h1111, 3, 0, 1, 0, 0);
        cycle("alu_r3", 1'b1, 16'h1111, 16'h0, 1'b1);
        drive(0, 0, 0, 0, 16'h0, 3, 0, 1, 0, 0);
        cycle("hold_r3", 1'b1, 16'h1111, 16'h0, 1'b1);
        drive(0, 1, 1, 3, 16'h00FF, 3, 0, 1, 0, 0);
        cycle("ld_r3", 1'b1, 16'h00FF, 16'h0, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 3, 0, 1, 0, 0);
        cycle("after_r3", 1'b1, 16'h00FF, 16'h0, 1'b0);

        // simultaneous set and clear of r4: the new load stays pending
        drive(0, 0, 0, 0, 16'h0, 0, 0, 1, 1, 4);
        cycle("issue_r4", 1'b1, 16'h0, 16'h0, 1'b0);
        drive(0, 1, 1, 4, 16'h4444, 0, 0, 1, 1, 4);
        cycle("setclr_r4", 1'b1, 16'h0, 16'h0, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 0, 4, 1, 0, 0);
        cycle("rd_r4", 1'b1, 16'h0, 16'h4444, 1'b1);
        drive(0, 1, 1, 4, 16'h5555, 0, 0, 1, 0, 0);
        cycle("clr_r4", 1'b0, 16'h0, 16'h0, 1'b0);

        // reset mid-operation drops pending loads
        drive(0, 0, 0, 0, 16'h0, 0, 0, 1, 1, 2);
        cycle("issue_r2", 1'b0, 16'h0, 16'h0, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 0, 0, 1, 1, 9);
        cycle("issue_r9", 1'b0, 16'h0, 16'h0, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 2, 9, 1, 0, 0);
        cycle("pend_r2r9", 1'b1, 16'h0, 16'h0, 1'b1);
        drive(1, 0, 0, 0, 16'h0, 2, 9, 0, 0, 0);
        cycle("mid_reset", 1'b0, 16'h0, 16'h0, 1'b0);
        drive(0, 0, 0, 0, 16'h0, 2, 9, 1, 0, 0);
        cycle("rd_r2r9", 1'b1, 16'h0, 16'h0, 1'b0);

        // randomized traffic against the reference model
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(49) == 0,
                  $urandom_range(1) == 1,
                  $urandom_range(1) == 1,
                  int'($urandom_range(15)),
                  16'($urandom),
                  int'($urandom_range(15)),
                  int'($urandom_range(15)),
                  $urandom_range(9) < 7,
                  $urandom_range(1) == 1,
                  int'($urandom_range(15)));
            cycle("rand", 1'b0, 16'h0, 16'h0, 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
